// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
// Arbitration priority states, grant owner encoding, byte-mask width.
package mem_arb_pkg;

    typedef enum logic {
        PRI_LS,
        PRI_IF
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_e;

    localparam int BMASK_W = 4;

endpackage

// File: rtl/mem_arb_prio_fsm.sv
// Anti-starvation priority FSM for the memory port arbiter.
// Hands priority to IF after STARVE_LIMIT consecutive lost IF cycles.
module mem_arb_prio_fsm
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_if_req,
    input  logic       i_if_gnt,
    output arb_state_e o_state
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;
    logic             if_lost;

    // Next lost-cycle count and priority state.
    always_comb begin
        if_lost = i_if_req && !i_if_gnt;
        wait_d  = '0;
        if (if_lost) begin
            wait_d = (wait_q == LIMIT) ? wait_q : wait_q + 1'b1;
        end
        state_d = state_q;
        case (state_q)
            PRI_LS: begin
                if (if_lost && (wait_d == LIMIT)) begin
                    state_d = PRI_IF;
                end
            end
            PRI_IF: begin
                if (i_if_gnt || !i_if_req) begin
                    state_d = PRI_LS;
                end
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= PRI_LS;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Combinational grant and mux, registered one-cycle response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_if_req,
    input  logic [ADDR_W-1:0]  i_if_addr,
    output logic               o_if_gnt,
    output logic               o_if_rvalid,
    output logic [DATA_W-1:0]  o_if_rdata,
    input  logic               i_ls_req,
    input  logic [ADDR_W-1:0]  i_ls_addr,
    input  logic [DATA_W-1:0]  i_ls_wdata,
    input  logic [BMASK_W-1:0] i_ls_bmask,
    input  logic               i_ls_wren,
    output logic               o_ls_gnt,
    output logic               o_ls_rvalid,
    output logic [DATA_W-1:0]  o_ls_rdata,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0]  o_mem_wdata,
    output logic [BMASK_W-1:0] o_mem_bmask,
    output logic               o_mem_wren,
    input  logic [DATA_W-1:0]  i_mem_rdata
);

    arb_state_e state;
    owner_e     owner;

    mem_arb_prio_fsm #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio_fsm (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_if_req(i_if_req),
        .i_if_gnt(o_if_gnt),
        .o_state (state)
    );

    // Pick the single winner for this cycle; nobody wins during reset.
    always_comb begin
        owner = OWN_NONE;
        if (!i_reset) begin
            if (state == PRI_IF) begin
                if (i_if_req) begin
                    owner = OWN_IF;
                end else if (i_ls_req) begin
                    owner = OWN_LS;
                end
            end else begin
                if (i_ls_req) begin
                    owner = OWN_LS;
                end else if (i_if_req) begin
                    owner = OWN_IF;
                end
            end
        end
    end

    assign o_if_gnt = (owner == OWN_IF);
    assign o_ls_gnt = (owner == OWN_LS);

    // Steer the winner onto the memory port; idle port never writes.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        o_mem_wren  = 1'b0;
        case (owner)
            OWN_LS: begin
                o_mem_addr  = i_ls_addr;
                o_mem_wdata = i_ls_wdata;
                o_mem_bmask = i_ls_bmask;
                o_mem_wren  = i_ls_wren;
            end
            OWN_IF: begin
                o_mem_addr = i_if_addr;
            end
            default: begin
            end
        endcase
    end

    // Capture read data for the winner; pulse its valid for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_if_rvalid <= 1'b0;
            o_ls_rvalid <= 1'b0;
            o_if_rdata  <= '0;
            o_ls_rdata  <= '0;
        end else begin
            o_if_rvalid <= (owner == OWN_IF);
            o_ls_rvalid <= (owner == OWN_LS);
            if (owner == OWN_IF) begin
                o_if_rdata <= i_mem_rdata;
            end
            if (owner == OWN_LS) begin
                o_ls_rdata <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed literal checks plus a randomized run against a behavioural model.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ls_req;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic        i_ls_wren;
    logic        o_ls_gnt;
    logic        o_ls_rvalid;
    logic [31:0] o_ls_rdata;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_gnt   (o_if_gnt),
        .o_if_rvalid(o_if_rvalid),
        .o_if_rdata (o_if_rdata),
        .i_ls_req   (i_ls_req),
        .i_ls_addr  (i_ls_addr),
        .i_ls_wdata (i_ls_wdata),
        .i_ls_bmask (i_ls_bmask),
        .i_ls_wren  (i_ls_wren),
        .o_ls_gnt   (o_ls_gnt),
        .o_ls_rvalid(o_ls_rvalid),
        .o_ls_rdata (o_ls_rdata),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask),
        .o_mem_wren (o_mem_wren),
        .i_mem_rdata(i_mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'hAABBCCDD;
        return (i * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old,
                                          logic [31:0] d,
                                          logic [3:0]  m);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        return w;
    endfunction

    // Memory the DUT drives: async read, byte-masked write on the edge.
    logic [31:0] mem [0:1023];
    assign i_mem_rdata = mem[o_mem_addr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (o_mem_wren) begin
                mem[o_mem_addr[11:2]] <= merge(mem[o_mem_addr[11:2]],
                                               o_mem_wdata, o_mem_bmask);
            end
        end
    end

    // Reference state.
    logic [31:0] ref_mem [0:1023];
    int          lost;
    logic        exp_if_rv;
    logic        exp_ls_rv;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_ls_rd;
    int          tests;
    int          fails;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Compare all outputs to the model, then advance the model one cycle.
    task automatic model_step();
        logic        eg_if;
        logic        eg_ls;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  eb;
        logic        ew;
        logic [31:0] old;
        eg_if = 1'b0;
        eg_ls = 1'b0;
        if (!i_reset) begin
            if (i_if_req && (lost >= STARVE_LIMIT || !i_ls_req))
                eg_if = 1'b1;
            else if (i_ls_req)
                eg_ls = 1'b1;
        end
        ea = 0; ed = 0; eb = 0; ew = 0;
        if (eg_ls) begin
            ea = i_ls_addr; ed = i_ls_wdata;
            eb = i_ls_bmask; ew = i_ls_wren;
        end else if (eg_if) begin
            ea = i_if_addr;
        end
        chk("if_gnt", o_if_gnt, eg_if);
        chk("ls_gnt", o_ls_gnt, eg_ls);
        chk("mem_addr", o_mem_addr, ea);
        chk("mem_wdata", o_mem_wdata, ed);
        chk("mem_bmask", o_mem_bmask, eb);
        chk("mem_wren", o_mem_wren, ew);
        chk("if_rvalid", o_if_rvalid, exp_if_rv);
        chk("if_rdata", o_if_rdata, exp_if_rd);
        chk("ls_rvalid", o_ls_rvalid, exp_ls_rv);
        chk("ls_rdata", o_ls_rdata, exp_ls_rd);
        if (i_reset) begin
            lost = 0;
            exp_if_rv = 0; exp_ls_rv = 0;
            exp_if_rd = 0; exp_ls_rd = 0;
        end else begin
            exp_if_rv = eg_if;
            exp_ls_rv = eg_ls;
            if (eg_if) exp_if_rd = ref_mem[i_if_addr[11:2]];
            if (eg_ls) begin
                old = ref_mem[i_ls_addr[11:2]];
                exp_ls_rd = old;
                if (i_ls_wren)
                    ref_mem[i_ls_addr[11:2]] = merge(old, i_ls_wdata,
                                                     i_ls_bmask);
            end
            if (i_if_req && !eg_if)
                lost = (lost < STARVE_LIMIT) ? lost + 1 : lost;
            else
                lost = 0;
        end
    endtask

    task automatic tick_neg();
        @(negedge clk);
        model_step();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pat(string name, logic want_if);
        chk({name, "_if"}, o_if_gnt, want_if);
        chk({name, "_ls"}, o_ls_gnt, !want_if);
    endtask

    logic ig;
    logic lg;

    initial begin
        tests = 0; fails = 0; lost = 0;
        exp_if_rv = 0; exp_ls_rv = 0;
        exp_if_rd = 0; exp_ls_rd = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        i_reset = 1; i_if_req = 1; i_if_addr = 32'h10;
        i_ls_req = 1; i_ls_addr = 32'h20; i_ls_wdata = 0;
        i_ls_bmask = 0; i_ls_wren = 0;
        to_pos();

        // Reset with both requests high.
        for (int r = 0; r < 2; r++) begin
            tick_neg();
            chk("rst_if_gnt", o_if_gnt, 0);
            chk("rst_ls_gnt", o_ls_gnt, 0);
            chk("rst_wren", o_mem_wren, 0);
            chk("rst_rvalid", {o_if_rvalid, o_ls_rvalid}, 0);
            to_pos();
        end
        i_reset = 0; i_if_req = 0; i_ls_req = 0;
        tick_neg();
        chk("rst_if_rdata", o_if_rdata, 0);
        chk("rst_ls_rdata", o_ls_rdata, 0);
        to_pos();

        // IF-only read of 0x10.
        i_if_req = 1; i_if_addr = 32'h10;
        tick_neg();
        chk("if_only_gnt", o_if_gnt, 1);
        to_pos();
        i_if_req = 0;
        tick_neg();
        chk("if_only_rv", o_if_rvalid, 1);
        chk("if_only_rd", o_if_rdata, 32'hDEADBEEF);
        to_pos();
        tick_neg();
        chk("if_only_pulse", o_if_rvalid, 0);
        to_pos();

        // Byte-masked store then IF read of the same word.
        i_ls_req = 1; i_ls_addr = 32'h20; i_ls_wren = 1;
        i_ls_wdata = 32'h11223344; i_ls_bmask = 4'b0011;
        tick_neg();
        chk("st_gnt", o_ls_gnt, 1);
        chk("st_wren", o_mem_wren, 1);
        to_pos();
        i_ls_req = 0; i_ls_wren = 0;
        i_if_req = 1; i_if_addr = 32'h20;
        tick_neg();
        chk("st_ack", o_ls_rvalid, 1);
        chk("st_old", o_ls_rdata, 32'hAABBCCDD);
        chk("rd_gnt", o_if_gnt, 1);
        to_pos();
        i_if_req = 0;
        tick_neg();
        chk("rd_new", o_if_rdata, 32'hAABB3344);
        to_pos();

        // Both requesting continuously.
        i_if_req = 1; i_if_addr = 32'h10;
        i_ls_req = 1; i_ls_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            tick_neg();
            chk_pat("starve", (i % 5) == 4);
            to_pos();
        end

        // IF drops its request while it holds priority.
        i_if_req = 0; i_ls_req = 0;
        tick_neg(); to_pos();
        i_if_req = 1; i_ls_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick_neg(); chk_pat("pre_drop", 0); to_pos();
        end
        i_if_req = 0;
        tick_neg();
        chk_pat("drop", 0);
        to_pos();
        i_if_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick_neg(); chk_pat("post_drop", i == 4); to_pos();
        end

        // Reset on the cycle IF would have been granted.
        for (int i = 0; i < 4; i++) begin
            tick_neg(); chk_pat("pre_rst", 0); to_pos();
        end
        i_reset = 1;
        tick_neg();
        chk("mid_rst_gnt", {o_if_gnt, o_ls_gnt}, 0);
        to_pos();
        i_reset = 0;
        for (int i = 0; i < 5; i++) begin
            tick_neg();
            if (i == 0)
                chk("post_rst_rv", {o_if_rvalid, o_ls_rvalid}, 0);
            chk_pat("post_rst", i == 4);
            to_pos();
        end

        // Randomized traffic.
        i_if_req = 0; i_ls_req = 0;
        for (int c = 0; c < 1500; c++) begin
            tick_neg();
            ig = o_if_gnt;
            lg = o_ls_gnt;
            to_pos();
            i_reset = ($urandom_range(0, 99) == 0);
            if (!i_if_req || ig) begin
                i_if_req = ($urandom_range(0, 3) != 0);
                i_if_addr = ($urandom_range(0, 1) == 0)
                          ? {27'd0, 3'($urandom_range(0, 7)), 2'b00}
                          : $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                i_if_req = 0;
            end
            if (!i_ls_req || lg) begin
                i_ls_req = ($urandom_range(0, 2) != 0);
                i_ls_addr = ($urandom_range(0, 1) == 0)
                          ? {27'd0, 3'($urandom_range(0, 7)), 2'b00}
                          : $urandom;
                i_ls_wdata = $urandom;
                i_ls_bmask = 4'($urandom);
                i_ls_wren = $urandom_range(0, 1) == 1;
            end
        end
        i_reset = 0; i_if_req = 0; i_ls_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick_neg(); to_pos();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
